// File: rtl/id_ex_register_pkg.sv
// Shared widths, constants and payload types for the ID/EX pipeline register.
package id_ex_register_pkg;

  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned FUNCT_W  = 10;
  localparam int unsigned BUBBLE_W = 16;

  localparam logic [BUBBLE_W-1:0] BUBBLE_SAT = {BUBBLE_W{1'b1}};

  typedef struct packed {
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
  } ctrl_t;

  typedef struct packed {
    ctrl_t              ctrl;
    logic [DATA_W-1:0]  data1;
    logic [DATA_W-1:0]  data2;
    logic [DATA_W-1:0]  imm;
    logic [FUNCT_W-1:0] funct;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
  } ex_payload_t;

  // A bubble kills every control and the destination index; operand fields
  // still load from the inputs so the datapath sees no extra hold muxing.
  function automatic ex_payload_t make_bubble(input ex_payload_t p);
    ex_payload_t b;
    b      = p;
    b.ctrl = '0;
    b.rd   = '0;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_register_if.sv
// ID-stage to EX-stage bundle: pipeline controls in, registered EX fields out.
interface id_ex_register_if;
  import id_ex_register_pkg::*;

  logic                start_i;
  logic                stall_i;
  logic                flush_i;
  logic                hazard_i;

  logic [ALUOP_W-1:0]  aluOp_i;
  logic                aluSrc_i;
  logic                memRead_i;
  logic                memWrite_i;
  logic                memToReg_i;
  logic                regWrite_i;
  logic [DATA_W-1:0]   data1_i;
  logic [DATA_W-1:0]   data2_i;
  logic [DATA_W-1:0]   imm_i;
  logic [FUNCT_W-1:0]  funct_i;
  logic [REG_W-1:0]    rs1_i;
  logic [REG_W-1:0]    rs2_i;
  logic [REG_W-1:0]    rd_i;

  logic [ALUOP_W-1:0]  aluOp_o;
  logic                aluSrc_o;
  logic                memRead_o;
  logic                memWrite_o;
  logic                memToReg_o;
  logic                regWrite_o;
  logic [DATA_W-1:0]   data1_o;
  logic [DATA_W-1:0]   data2_o;
  logic [DATA_W-1:0]   imm_o;
  logic [FUNCT_W-1:0]  funct_o;
  logic [REG_W-1:0]    rs1_o;
  logic [REG_W-1:0]    rs2_o;
  logic [REG_W-1:0]    rd_o;
  logic                valid_o;
  logic [BUBBLE_W-1:0] bubble_cnt_o;

  modport master (
    output start_i, stall_i, flush_i, hazard_i,
    output aluOp_i, aluSrc_i, memRead_i, memWrite_i, memToReg_i, regWrite_i,
    output data1_i, data2_i, imm_i, funct_i, rs1_i, rs2_i, rd_i,
    input  aluOp_o, aluSrc_o, memRead_o, memWrite_o, memToReg_o, regWrite_o,
    input  data1_o, data2_o, imm_o, funct_o, rs1_o, rs2_o, rd_o,
    input  valid_o, bubble_cnt_o
  );

  modport slave (
    input  start_i, stall_i, flush_i, hazard_i,
    input  aluOp_i, aluSrc_i, memRead_i, memWrite_i, memToReg_i, regWrite_i,
    input  data1_i, data2_i, imm_i, funct_i, rs1_i, rs2_i, rd_i,
    output aluOp_o, aluSrc_o, memRead_o, memWrite_o, memToReg_o, regWrite_o,
    output data1_o, data2_o, imm_o, funct_o, rs1_o, rs2_o, rd_o,
    output valid_o, bubble_cnt_o
  );

endinterface

// File: rtl/id_ex_register_bubble_counter.sv
// Saturating bubble counter: counts enabled events, sticks at all-ones.
module id_ex_register_bubble_counter
  import id_ex_register_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_i,
  output logic [BUBBLE_W-1:0] cnt_o
);

  logic [BUBBLE_W-1:0] cnt_d;
  logic [BUBBLE_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != BUBBLE_SAT)) begin
      cnt_d = cnt_q + BUBBLE_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with run/stall gating, flush bubbles and a
// saturating count of inserted bubbles. All outputs come straight from flops.
module id_ex_register
  import id_ex_register_pkg::*;
(
  input logic             clk_i,
  input logic             rst_i,
  id_ex_register_if.slave bus
);

  ex_payload_t         pl_in_c;
  ex_payload_t         payload_d;
  ex_payload_t         payload_q;
  logic                valid_d;
  logic                valid_q;
  logic                load_c;
  logic                bubble_c;
  logic [BUBBLE_W-1:0] bubble_cnt;

  // Stall dominates flush: a flush seen while stalled is simply not loaded.
  assign load_c   = bus.start_i & ~bus.stall_i;
  assign bubble_c = load_c & (bus.flush_i | bus.hazard_i);

  always_comb begin
    pl_in_c                 = '0;
    pl_in_c.ctrl.alu_op     = bus.aluOp_i;
    pl_in_c.ctrl.alu_src    = bus.aluSrc_i;
    pl_in_c.ctrl.mem_read   = bus.memRead_i;
    pl_in_c.ctrl.mem_write  = bus.memWrite_i;
    pl_in_c.ctrl.mem_to_reg = bus.memToReg_i;
    pl_in_c.ctrl.reg_write  = bus.regWrite_i;
    pl_in_c.data1           = bus.data1_i;
    pl_in_c.data2           = bus.data2_i;
    pl_in_c.imm             = bus.imm_i;
    pl_in_c.funct           = bus.funct_i;
    pl_in_c.rs1             = bus.rs1_i;
    pl_in_c.rs2             = bus.rs2_i;
    pl_in_c.rd              = bus.rd_i;
  end

  // Hazard controls are already zeroed upstream; here it only clears valid.
  always_comb begin
    payload_d = payload_q;
    valid_d   = valid_q;
    if (load_c) begin
      if (bus.flush_i) begin
        payload_d = make_bubble(pl_in_c);
        valid_d   = 1'b0;
      end else begin
        payload_d = pl_in_c;
        valid_d   = ~bus.hazard_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      payload_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      payload_q <= payload_d;
      valid_q   <= valid_d;
    end
  end

  id_ex_register_bubble_counter u_bubble_counter (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (bubble_c),
    .cnt_o (bubble_cnt)
  );

  assign bus.aluOp_o      = payload_q.ctrl.alu_op;
  assign bus.aluSrc_o     = payload_q.ctrl.alu_src;
  assign bus.memRead_o    = payload_q.ctrl.mem_read;
  assign bus.memWrite_o   = payload_q.ctrl.mem_write;
  assign bus.memToReg_o   = payload_q.ctrl.mem_to_reg;
  assign bus.regWrite_o   = payload_q.ctrl.reg_write;
  assign bus.data1_o      = payload_q.data1;
  assign bus.data2_o      = payload_q.data2;
  assign bus.imm_o        = payload_q.imm;
  assign bus.funct_o      = payload_q.funct;
  assign bus.rs1_o        = payload_q.rs1;
  assign bus.rs2_o        = payload_q.rs2;
  assign bus.rd_o         = payload_q.rd;
  assign bus.valid_o      = valid_q;
  assign bus.bubble_cnt_o = bubble_cnt;

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_i  input  1  reset, asynchronous, active-high.
REQ-003 start_i  input  1  pipeline run enable; 0 = hold all state.
REQ-004 stall_i  input  1  memory stall; 1 = hold all state.
REQ-005 flush_i  input  1  branch flush; 1 = load a bubble.
REQ-006 hazard_i  input  1  load-use hazard flag, already applied to controls upstream; used for counting and valid only.
REQ-007 aluOp_i  input  2; aluSrc_i, memRead_i, memWrite_i, memToReg_i, regWrite_i  input  1 each: ID-stage controls.
REQ-008 data1_i, data2_i, imm_i  input  32 each: register operands and sign-extended immediate.
REQ-009 funct_i  input  10  {funct7,funct3}; rs1_i, rs2_i, rd_i  input  5 each.
REQ-010 Outputs mirror REQ-007..009 with _o suffix and identical widths.
REQ-011 valid_o  output  1  1 = EX holds a real instruction.
REQ-012 bubble_cnt_o  output  16  saturating count of bubbles inserted.

Function
REQ-013 Update enable: load = start_i & ~stall_i; when load=0, every output holds.
REQ-014 Load, flush_i=0: all _o take their _i values next edge; valid_o = ~hazard_i; latency exactly 1 cycle.
REQ-015 Load, flush_i=1: aluOp_o=0, all 1-bit controls=0, rd_o=0, valid_o=0; data/imm/funct/rs fields may load or hold (don't-care, implementer picks one, documented).
REQ-016 Bubble event = load & (flush_i | hazard_i); bubble_cnt_o increments by 1 per event.
REQ-017 bubble_cnt_o saturates at 16'hFFFF, never wraps.
REQ-018 stall_i has priority over flush_i; flush_i during stall is ignored and upstream holds flush_i until stall_i drops.
REQ-019 flush_i and hazard_i together count as one bubble.
REQ-020 No output is a combinational function of any input (pure registered outputs).

Reset
REQ-021 rst_i=1 forces immediately, independent of clk_i: every control, data, index output = 0, valid_o=0, bubble_cnt_o=0.
REQ-022 Reset asserted mid-stall or mid-flush discards held state; first load after rst_i falls behaves per REQ-014/015.
REQ-023 While rst_i=1, start_i, stall_i, flush_i have no effect.

Structure
REQ-024 Shared package holds: ALUOP width (2), data width (32), register index width (5), funct width (10), bubble counter width (16) and its saturation constant.
REQ-025 One sub-module, bubble_counter (16-bit saturating, async reset, increment enable), is natural; remainder is flat registers.

Verification
REQ-026 Reset: rst_i pulse between edges -> all outputs 0 before next clk_i edge, valid_o=0, bubble_cnt_o=0.
REQ-027 Pass-through: start_i=1, regWrite_i=1, rd_i=5'd7, data1_i=32'h1234_5678 -> next edge regWrite_o=1, rd_o=7, data1_o=32'h1234_5678, valid_o=1.
REQ-028 Stall hold: load values, then stall_i=1 for 3 cycles with changing inputs -> outputs unchanged 3 cycles; bubble_cnt_o unchanged.
REQ-029 Flush: memWrite_i=1, rd_i=9, flush_i=1 -> next edge memWrite_o=0, rd_o=0, valid_o=0, bubble_cnt_o +1.
REQ-030 Stall+flush: stall_i=1, flush_i=1 for 2 cycles then stall_i=0 with flush_i=1 -> no change during stall, exactly one bubble after, bubble_cnt_o +1.
REQ-031 Saturation: preload via 65535 bubbles, then hazard_i=1 five more loads -> bubble_cnt_o stays 16'hFFFF.
